// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between
// NREQ requesters. It grants at most one access per cycle, drives the memory
// port in the same cycle, and routes each read response back to its issuer
// RD_LAT cycles later.
// Optional feature: define MEM_ARB_LOCK_EN to add a grant-lock FSM that lets
// a requester hold the memory across consecutive transfers via req_lock.
module mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last_r;
  logic [NREQ-1:0] elig_s;
  logic            found_s;
  logic [IW-1:0]   gidx_s;
  logic [IW:0]     cand_s;
  logic            xfer_s;
  logic [RD_LAT-1:0] pipe_v_r;
  logic [IW-1:0]   pipe_i_r [RD_LAT];

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [0:0] {ARB = 1'b0, LOCKED = 1'b1} lock_state_t;
  lock_state_t   state_r;
  logic [IW-1:0] owner_r;

  // While locked, only the owner may compete for the memory.
  always_comb begin
    elig_s = req_valid;
    if (state_r == LOCKED) begin
      elig_s          = {NREQ{1'b0}};
      elig_s[owner_r] = req_valid[owner_r];
    end else begin
      elig_s = req_valid;
    end
  end

  // Lock FSM: enter on a locked transfer, leave on an unlocked transfer or owner idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ARB;
      owner_r <= {IW{1'b0}};
    end else begin
      case (state_r)
        ARB: begin
          if (xfer_s && req_lock[gidx_s]) begin
            state_r <= LOCKED;
            owner_r <= gidx_s;
          end else begin
            state_r <= ARB;
          end
        end
        LOCKED: begin
          if (!req_valid[owner_r]) begin
            state_r <= ARB;
          end else if (xfer_s && !req_lock[owner_r]) begin
            state_r <= ARB;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: state_r <= ARB;
      endcase
    end
  end
`else
  logic unused_lock_s;
  assign elig_s        = req_valid;
  assign unused_lock_s = |req_lock;
`endif

  // Round-robin search starting one past the last winner, wrapping modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = {IW{1'b0}};
    cand_s  = {(IW+1){1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_r} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && elig_s[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        gidx_s  = cand_s[IW-1:0];
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  assign xfer_s = found_s & ~reset;

  // Drive the grant and the memory port from the winning requester.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (xfer_s) begin
      req_ready[gidx_s] = 1'b1;
      mem_en            = 1'b1;
      mem_we            = req_we[gidx_s];
      mem_addr          = req_addr[gidx_s*AW +: AW];
      mem_wdata         = req_wdata[gidx_s*DW +: DW];
    end else begin
      req_ready = {NREQ{1'b0}};
      mem_en    = 1'b0;
    end
  end

  // Priority pointer: remember the last winner so it goes to the back of the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= IW'(NREQ-1);
    end else if (xfer_s) begin
      last_r <= gidx_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Read tracker: one {valid, index} slot per cycle of memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_i_r[i] <= {IW{1'b0}};
      end
    end else begin
      pipe_v_r[0] <= xfer_s & ~mem_we;
      pipe_i_r[0] <= gidx_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_i_r[i] <= pipe_i_r[i-1];
      end
    end
  end

  // Route returning read data to its issuer; quiet while reset is held.
  always_comb begin
    rsp_valid = {NREQ{1'b0}};
    rsp_rdata = {DW{1'b0}};
    if (pipe_v_r[RD_LAT-1] && !reset) begin
      rsp_valid[pipe_i_r[RD_LAT-1]] = 1'b1;
      rsp_rdata                     = mem_rdata;
    end else begin
      rsp_valid = {NREQ{1'b0}};
      rsp_rdata = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a behavioural memory model and a
// scoreboard of expected read responses (index, data, due cycle).
module tb_mem_arbiter;

  localparam int NREQ   = 4;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic               mem_en, mem_we;
  logic [AW-1:0]      mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 257) ^ 16'h1234;
  endfunction

  // Memory model with RD_LAT cycles of read latency.
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  bit            mem_init_r = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_r) begin
      for (int a = 0; a < 256; a++) mem_arr[a] <= init_val(a);
      mem_init_r <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_arr[mem_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] shadow [256];
  bit            sh_init_r = 1'b0;
  logic [AW-1:0] mon_addr;

  // Monitor: log transfers, predict read data, and retire due responses.
  always @(negedge clk) begin
    if (!sh_init_r) begin
      for (int a = 0; a < 256; a++) shadow[a] <= init_val(a);
      sh_init_r <= 1'b1;
    end
    if (reset) begin
      sb.delete();
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_mem_en", mem_en, 0);
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check_eq("rsp_valid", rsp_valid, 32'(4'b0001 << mon_e.idx));
        check_eq("rsp_rdata", rsp_rdata, mon_e.data);
      end else if (rsp_valid != 0) begin
        check_eq("rsp_unexpected", rsp_valid, 0);
      end else if (rsp_rdata != 0) begin
        check_eq("rsp_rdata_idle", rsp_rdata, 0);
      end
      if (req_ready != 0) begin
        check_eq("ready_onehot", $onehot(req_ready), 1);
        check_eq("ready_wo_valid", req_ready & ~req_valid, 0);
        check_eq("mem_en", mem_en, 1);
      end else if (mem_en) begin
        check_eq("mem_en_idle", mem_en, 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_addr = req_addr[i*AW +: AW];
          check_eq("mem_addr", mem_addr, mon_addr);
          check_eq("mem_we", mem_we, req_we[i]);
          if (req_we[i]) begin
            check_eq("mem_wdata", mem_wdata, req_wdata[i*DW +: DW]);
            shadow[mon_addr] <= req_wdata[i*DW +: DW];
          end else begin
            sb.push_back('{i, shadow[mon_addr], cyc + RD_LAT});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_lock[i]            = lk;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic expect_grant(input string tag, input logic [NREQ-1:0] exp);
    @(negedge clk);
    check_eq(tag, req_ready, exp);
    tick();
  endtask

  logic [NREQ-1:0] ga [5];
  logic [NREQ-1:0] gb [4];
  bit got;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle outputs right after reset
    @(negedge clk);
    check_eq("post_rst_ready", req_ready, 0);
    check_eq("post_rst_mem_en", mem_en, 0);
    check_eq("post_rst_mem_addr", mem_addr, 0);
    check_eq("post_rst_rsp", rsp_valid, 0);
    check_eq("post_rst_rdata", rsp_rdata, 0);
    tick();

    // All four requesters read continuously
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'((i + 1) * 16), 16'h0000, 1'b0);
    for (int k = 0; k < 12; k++) expect_grant("rr_grant", 4'b0001 << (k % 4));
    clear_all();
    repeat (RD_LAT + 2) tick();

    // Write then read-after-write
    set_req(2, 1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0);
    @(negedge clk);
    check_eq("wr_ready", req_ready, 4'b0100);
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_addr", mem_addr, 8'h05);
    check_eq("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    set_req(2, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b0);
    set_req(1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0);
    expect_grant("raw_rd_grant", 4'b0010);
    clear_all();
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        got = 1'b1;
        check_eq("raw_rdata", rsp_rdata, 16'hBEEF);
      end
    end
    check_eq("raw_rsp_seen", got, 1);
    tick();
    repeat (2) tick();

    // Single requester streams, then requester 0 joins
    set_req(3, 1'b1, 1'b0, 8'h33, 16'h0000, 1'b0);
    repeat (5) expect_grant("solo3_grant", 4'b1000);
    set_req(0, 1'b1, 1'b0, 8'h01, 16'h0000, 1'b0);
    expect_grant("join0_grant", 4'b0001);
    expect_grant("join3_grant", 4'b1000);
    clear_all();
    repeat (RD_LAT + 2) tick();

    // Reset with reads in flight
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b0, AW'(8'h11 + k), 16'h0000, 1'b0);
      expect_grant("inflight_grant", 4'b0001);
    end
    clear_all();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("inrst_rsp", rsp_valid, 0);
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("afterrst_rsp", rsp_valid, 0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(8'h60 + i), 16'h0000, 1'b0);
    expect_grant("rst_last_grant", 4'b0001);
    clear_all();
    repeat (RD_LAT + 2) tick();

    // No requests for ten cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("idle_mem_en", mem_en, 0);
      check_eq("idle_ready", req_ready, 0);
      tick();
    end

    // Locked burst by requester 1 against a continuously valid requester 2
`ifdef MEM_ARB_LOCK_EN
    ga = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    gb = '{4'b0010, 4'b0010, 4'b0000, 4'b0100};
`else
    ga = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100};
    gb = '{4'b0010, 4'b0100, 4'b0100, 4'b0100};
`endif
    for (int k = 0; k < 5; k++) begin
      set_req(1, k < 4, 1'b0, 8'h21, 16'h0000, k < 3);
      set_req(2, 1'b1, 1'b0, 8'h50, 16'h0000, 1'b0);
      expect_grant("lock_a_grant", ga[k]);
    end
    clear_all();
    repeat (RD_LAT + 2) tick();

    // Lock owner drops valid mid-lock
    for (int k = 0; k < 4; k++) begin
      set_req(1, k < 2, 1'b0, 8'h22, 16'h0000, 1'b1);
      set_req(2, 1'b1, 1'b0, 8'h51, 16'h0000, 1'b0);
      expect_grant("lock_b_grant", gb[k]);
    end
    clear_all();
    repeat (RD_LAT + 3) tick();

    check_eq("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port `mod_mem`-style memory between `NREQ` requesters. It grants at most one access per cycle and drives the memory port. Each read response is routed back to the requester that issued it, after the memory's fixed read latency. It sits between the compute/load units and the memory instance in the test top.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `AW`, 8: address width
- `DW`, 16: data width
- `RD_LAT`, 1: memory read latency in cycles (1..4)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot grant; transfer when `valid & ready`
- `req_we`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*AW  packed; requester i at `[i*AW +: AW]`
- `req_wdata`  in  NREQ*DW  packed likewise
- `req_lock`  in  NREQ  hold grant (only with `MEM_ARB_LOCK_EN`; otherwise ignored)
- `rsp_valid`  out  NREQ  one-hot read-data strobe
- `rsp_rdata`  out  DW  read data, shared by all requesters
- `mem_en`, `mem_we`  out  1  memory strobe, write enable
- `mem_addr`  out  AW; `mem_wdata`  out  DW
- `mem_rdata`  in  DW  valid `RD_LAT` cycles after `mem_en` with `mem_we=0`

## Operation
- Priority pointer `last` (log2 NREQ bits). Search order: `last+1, last+2, …`, wrapping modulo NREQ. The first requester with `req_valid` set is granted.
- Grant is combinational from `req_valid` and `last`. `req_ready` has exactly one bit set, or none if no bit of `req_valid` is set.
- Granted request drives `mem_en=1`, `mem_we`, `mem_addr`, `mem_wdata` in the same cycle.
- If nothing is granted: `mem_en=0`, `mem_we=0`. Address/data are don't-care but driven to 0.
- On a transfer, `last` ← granted index at the clock edge. With no transfer, `last` holds.
- Read tracking: a shift register `RD_LAT` deep holds {valid, index}, one entry per issued read.
  - At the tail, `rsp_valid[index]=1`.
  - `rsp_rdata = mem_rdata` (pass-through); equal to 0 when no `rsp_valid` bit is set.
- Writes produce no response.
- Reads and writes may be issued back-to-back every cycle. Responses stay in issue order; no backpressure on responses.

## Timing
- Reset state (next edge with `reset=1`):
  - `last = NREQ-1`, so requester 0 wins first.
  - Read pipeline cleared.
  - All outputs 0 during and after reset until new requests arrive. `req_ready` is forced to 0 while `reset=1`.
- Request-to-memory latency is 0 cycles (same cycle as transfer).
- Read data at the requester is `RD_LAT` cycles after the transfer.
- Throughput is 1 access/cycle.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- A requester whose `req_valid` drops while ungranted loses nothing. `last` is unaffected.
- Reset asserted while reads are in flight: pending responses are discarded, and no `rsp_valid` appears after reset.
- Requester inputs must be stable while `req_valid=1` and the request is ungranted.

## Configuration
- `MEM_ARB_LOCK_EN` defined: adds the lock FSM.
  - States: `ARB` (normal round-robin) and `LOCKED` (owner index held).
  - `ARB`→`LOCKED` on a transfer with `req_lock[g]=1`.
  - In `LOCKED`:
    - Only the owner is eligible.
    - A transfer with `req_lock=0` → `ARB`.
    - Owner's `req_valid=0` for a cycle → `ARB` (no grant that cycle).
  - `last` updates as normal.
- Not defined:
  - `req_lock` is unconnected internally.
  - Pure round-robin; no FSM state.

## Test plan
- After reset, all four requesters read addr 0x10/0x20/0x30/0x40 continuously:
  - Grants go 0,1,2,3,0…
  - `rsp_valid` one-hot follows the same order `RD_LAT` cycles later.
  - `rsp_rdata` matches the memory contents.
- Requester 2 writes 0xBEEF to 0x05, then requester 1 reads 0x05 the next cycle → `rsp_valid[1]` with data 0xBEEF.
- Only requester 3 valid for 5 cycles → granted every cycle; `last=3`. Requester 0 then joins → 0 is granted next, then 3.
- `RD_LAT=3`: issue 3 reads, then assert `reset` one cycle after the last read → no `rsp_valid` during or after reset; `last=NREQ-1`.
- No requests for 10 cycles → `mem_en=0` and `req_ready=0` throughout.
- With `MEM_ARB_LOCK_EN`: requester 1 issues 3 locked reads, then an unlocked read, while requester 2 is valid throughout → grants 1,1,1,1, then 2.
  - Repeat with requester 1 dropping valid mid-lock → grant moves to 2 the cycle after the drop.
